// File: rtl/cpu1_button_pio_if.sv
// Avalon-MM slave bus bundle for the CPU1 button PIO.
// The master modport is the interconnect side, and the slave modport is the PIO side.
interface cpu1_button_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/cpu1_button_pio.sv
// CPU1 button/sensor input PIO: synchronises, debounces and edge-captures WIDTH lines.
// Raises a maskable level interrupt and exposes the state on a zero-wait Avalon-MM slave.
module cpu1_button_pio #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    cpu1_button_pio_if.slave bus,
    input  logic [WIDTH-1:0] in_port
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("cpu1_button_pio: WIDTH must be 1..32");
    end
    if (DEBOUNCE_CYCLES < 2 || (64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt
        $error("cpu1_button_pio: need DEBOUNCE_CYCLES >= 2 and 2**CNT_W > DEBOUNCE_CYCLES");
    end

    logic [WIDTH-1:0] sync1_p0;
    logic [WIDTH-1:0] sync2_p1;
    logic [WIDTH-1:0] stable_p2;
    logic [WIDTH-1:0] stable_d_p3;
    logic [CNT_W-1:0] cnt_p2 [WIDTH];
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] wr_clr;
    logic             wr_en;
    logic             unused_wdata;

    // Stage p0/p1: two-flop synchroniser for the asynchronous inputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_p0 <= '0;
            sync2_p1 <= '0;
        end else begin
            sync1_p0 <= in_port;
            sync2_p1 <= sync1_p0;
        end
    end

    // Stage p2: per-bit debounce, a new level must persist DEBOUNCE_CYCLES edges
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_p2 <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_p2[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2_p1[i] == stable_p2[i]) begin
                    cnt_p2[i] <= '0;
                end else if (cnt_p2[i] == CNT_LAST) begin
                    stable_p2[i] <= sync2_p1[i];
                    cnt_p2[i]    <= '0;
                end else begin
                    cnt_p2[i] <= cnt_p2[i] + 1'b1;
                end
            end
        end
    end

    // Stage p3: delayed copy for rising-edge detection and sticky capture
    assign wr_en  = bus.chipselect & ~bus.write_n;
    assign wr_clr = (wr_en && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;
    assign rise   = stable_p2 & ~stable_d_p3;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_d_p3  <= '0;
            edge_capture <= '0;
            irq_mask     <= '0;
        end else begin
            stable_d_p3  <= stable_p2;
            // A capture landing on the same edge as its clear must not be lost
            edge_capture <= (edge_capture & ~wr_clr) | rise;
            if (wr_en && bus.address == 2'd2) begin
                irq_mask <= bus.writedata[WIDTH-1:0];
            end
        end
    end

    // Register read-back, combinational from address
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            2'd0:    bus.readdata[WIDTH-1:0] = stable_p2;
            2'd2:    bus.readdata[WIDTH-1:0] = irq_mask;
            2'd3:    bus.readdata[WIDTH-1:0] = edge_capture;
            default: bus.readdata = '0;
        endcase
    end

    assign bus.irq      = |(edge_capture & irq_mask);
    assign unused_wdata = ^bus.writedata;

endmodule

// File: tb/tb_cpu1_button_pio.sv
// Self-checking bench for cpu1_button_pio: directed scenarios plus randomized traffic
// compared against a window-based behavioural model of debounce and capture.
module tb_cpu1_button_pio;
    localparam int W = 4;
    localparam int D = 4;

    logic         clk     = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] in_port = '0;
    int           total   = 0;
    int           bad     = 0;

    cpu1_button_pio_if bus ();

    cpu1_button_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .in_port (in_port)
    );

    always #5 clk = ~clk;

    // Reference model: samp[k] holds in_port seen k+1 edges ago; the synchronised
    // value at an edge is samp[1], and a bit flips once D such values all differ.
    logic [W-1:0] samp [0:D];
    logic [W-1:0] m_stable, m_prev, m_cap, m_mask;

    function automatic logic [W-1:0] settled(input logic [W-1:0] cur);
        logic [W-1:0] r;
        bit all_diff;
        r = cur;
        for (int i = 0; i < W; i++) begin
            all_diff = 1'b1;
            for (int k = 1; k <= D; k++) begin
                if (samp[k][i] == cur[i]) all_diff = 1'b0;
            end
            if (all_diff) r[i] = ~cur[i];
        end
        return r;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k <= D; k++) samp[k] <= '0;
            m_stable <= '0;
            m_prev   <= '0;
            m_cap    <= '0;
            m_mask   <= '0;
        end else begin
            samp[0] <= in_port;
            for (int k = 1; k <= D; k++) samp[k] <= samp[k-1];
            m_stable <= settled(m_stable);
            m_prev   <= m_stable;
            if (bus.chipselect && !bus.write_n && bus.address == 2'd2)
                m_mask <= bus.writedata[W-1:0];
            if (bus.chipselect && !bus.write_n && bus.address == 2'd3)
                m_cap <= (m_cap & ~bus.writedata[W-1:0]) | (m_stable & ~m_prev);
            else
                m_cap <= m_cap | (m_stable & ~m_prev);
        end
    end

    function automatic logic [31:0] exp_rd(input logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_stable);
            2'd2:    return 32'(m_mask);
            2'd3:    return 32'(m_cap);
            default: return 32'd0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic read_at(input logic [1:0] a, output logic [31:0] d);
        bus.address = a;
        #1;
        d = bus.readdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        bus_write(2'd2, 32'hF);
        in_port = 4'hF;
        repeat (10) step();
        total++;
        if (bus.irq !== 1'b1) begin
            bad++; $display("FAIL reset_pre_irq: got %b want 1", bus.irq);
        end
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        for (int a = 0; a < 4; a++) begin
            read_at(2'(a), d);
            total++;
            if (d !== 32'd0) begin
                bad++; $display("FAIL reset_async_rd%0d: got %h want 0", a, d);
            end
        end
        total++;
        if (bus.irq !== 1'b0) begin
            bad++; $display("FAIL reset_async_irq: got %b want 0", bus.irq);
        end
        in_port = '0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) step();
        for (int a = 0; a < 4; a++) begin
            read_at(2'(a), d);
            total++;
            if (d !== 32'd0) begin
                bad++; $display("FAIL reset_after_rd%0d: got %h want 0", a, d);
            end
        end
        total++;
        if (bus.irq !== 1'b0) begin
            bad++; $display("FAIL reset_after_irq: got %b want 0", bus.irq);
        end
    endtask

    task automatic test_clean_press();
        logic [31:0] d;
        do_reset();
        in_port = '0;
        repeat (3) step();
        in_port = 4'b0001;
        for (int n = 1; n <= 9; n++) begin
            step();
            read_at(2'd0, d);
            total++;
            if (d !== ((n >= 6) ? 32'h1 : 32'h0)) begin
                bad++; $display("FAIL press_data edge%0d: got %h want %h", n, d, (n >= 6) ? 1 : 0);
            end
            read_at(2'd3, d);
            total++;
            if (d !== ((n >= 7) ? 32'h1 : 32'h0)) begin
                bad++; $display("FAIL press_capture edge%0d: got %h want %h", n, d, (n >= 7) ? 1 : 0);
            end
            total++;
            if (bus.irq !== 1'b0) begin
                bad++; $display("FAIL press_irq edge%0d: got %b want 0", n, bus.irq);
            end
        end
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        do_reset();
        in_port = '0;
        repeat (3) step();
        in_port = 4'b0010;
        for (int n = 1; n <= 12; n++) begin
            step();
            if (n == 3) in_port = '0;
            read_at(2'd0, d);
            total++;
            if (d !== 32'h0) begin
                bad++; $display("FAIL glitch_data edge%0d: got %h want 0", n, d);
            end
            read_at(2'd3, d);
            total++;
            if (d !== 32'h0) begin
                bad++; $display("FAIL glitch_capture edge%0d: got %h want 0", n, d);
            end
        end
        in_port = 4'b0010;
        for (int n = 1; n <= 12; n++) begin
            step();
            if (n == 4) in_port = '0;
            read_at(2'd0, d);
            total++;
            if (d !== ((n >= 6 && n <= 9) ? 32'h2 : 32'h0)) begin
                bad++; $display("FAIL pulse4_data edge%0d: got %h want %h", n, d, (n >= 6 && n <= 9) ? 2 : 0);
            end
            read_at(2'd3, d);
            total++;
            if (d !== ((n >= 7) ? 32'h2 : 32'h0)) begin
                bad++; $display("FAIL pulse4_capture edge%0d: got %h want %h", n, d, (n >= 7) ? 2 : 0);
            end
        end
    endtask

    task automatic test_irq_mask();
        logic [31:0] d;
        do_reset();
        in_port = 4'b0001;
        repeat (9) step();
        total++;
        if (bus.irq !== 1'b0) begin
            bad++; $display("FAIL irq_unmasked_idle: got %b want 0", bus.irq);
        end
        bus_write(2'd2, 32'h1);
        total++;
        if (bus.irq !== 1'b1) begin
            bad++; $display("FAIL irq_mask_set: got %b want 1", bus.irq);
        end
        read_at(2'd2, d);
        total++;
        if (d !== 32'h1) begin
            bad++; $display("FAIL irq_mask_read: got %h want 1", d);
        end
        bus_write(2'd2, 32'h0);
        total++;
        if (bus.irq !== 1'b0) begin
            bad++; $display("FAIL irq_mask_zero: got %b want 0", bus.irq);
        end
        read_at(2'd3, d);
        total++;
        if (d !== 32'h1) begin
            bad++; $display("FAIL irq_capture_kept: got %h want 1", d);
        end
        bus_write(2'd2, 32'h1);
        bus_write(2'd3, 32'h1);
        total++;
        if (bus.irq !== 1'b0) begin
            bad++; $display("FAIL irq_after_clear: got %b want 0", bus.irq);
        end
        read_at(2'd3, d);
        total++;
        if (d !== 32'h0) begin
            bad++; $display("FAIL irq_capture_cleared: got %h want 0", d);
        end
    endtask

    task automatic test_collision();
        logic [31:0] d;
        do_reset();
        in_port = 4'hB;
        repeat (10) step();
        read_at(2'd3, d);
        total++;
        if (d !== 32'hB) begin
            bad++; $display("FAIL collide_pre: got %h want b", d);
        end
        in_port = 4'hF;
        repeat (6) step();
        bus_write(2'd3, 32'hF);
        read_at(2'd3, d);
        total++;
        if (d !== 32'h4) begin
            bad++; $display("FAIL collide_capture: got %h want 4", d);
        end
        read_at(2'd0, d);
        total++;
        if (d !== 32'hF) begin
            bad++; $display("FAIL collide_data: got %h want f", d);
        end
    endtask

    task automatic test_reset_mid_debounce();
        logic [31:0] d;
        do_reset();
        in_port = '0;
        repeat (3) step();
        in_port = 4'b1000;
        repeat (4) step();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            step();
            read_at(2'd0, d);
            total++;
            if (d !== ((n >= 6) ? 32'h8 : 32'h0)) begin
                bad++; $display("FAIL midrst_data edge%0d: got %h want %h", n, d, (n >= 6) ? 8 : 0);
            end
            read_at(2'd3, d);
            total++;
            if (d !== ((n >= 7) ? 32'h8 : 32'h0)) begin
                bad++; $display("FAIL midrst_capture edge%0d: got %h want %h", n, d, (n >= 7) ? 8 : 0);
            end
        end
        bus_write(2'd3, 32'h8);
        repeat (6) step();
        read_at(2'd3, d);
        total++;
        if (d !== 32'h0) begin
            bad++; $display("FAIL midrst_single_capture: got %h want 0", d);
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [1:0]  a;
        int          hold;
        do_reset();
        hold = 0;
        for (int n = 0; n < 800; n++) begin
            if (hold == 0) begin
                in_port = in_port ^ W'($urandom_range(1, 15));
                hold    = $urandom_range(1, 8);
            end
            hold--;
            bus.chipselect = 1'($urandom_range(0, 1));
            bus.write_n    = ($urandom_range(0, 3) != 0);
            bus.address    = 2'($urandom_range(0, 3));
            bus.writedata  = $urandom;
            step();
            bus.chipselect = 1'b0;
            bus.write_n    = 1'b1;
            a = 2'($urandom_range(0, 3));
            read_at(a, d);
            total++;
            if (d !== exp_rd(a)) begin
                bad++; $display("FAIL random_rd%0d cycle%0d: got %h want %h", a, n, d, exp_rd(a));
            end
            total++;
            if (bus.irq !== |(m_cap & m_mask)) begin
                bad++; $display("FAIL random_irq cycle%0d: got %b want %b", n, bus.irq, |(m_cap & m_mask));
            end
        end
    endtask

    initial begin
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'd0;
        test_reset();
        test_clean_press();
        test_glitch();
        test_irq_mask();
        test_collision();
        test_reset_mid_debounce();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
